// File: rtl/compare_alarm_monitor.sv
// Alarm monitor downstream of the 4-bit magnitude comparator: debounces A>B into a
// hysteretic alarm with edge pulses, and keeps saturating outcome counters plus a sticky error.
module compare_alarm_monitor #(
  parameter int CNT_W   = 8,
  parameter int RUN_LEN = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             A_greater,
  input  logic             A_equal,
  input  logic             A_less,
  input  logic             clear_counts,
  output logic             alarm,
  output logic             alarm_rise,
  output logic             alarm_fall,
  output logic [CNT_W-1:0] gt_count,
  output logic [CNT_W-1:0] eq_count,
  output logic [CNT_W-1:0] lt_count,
  output logic             flag_error
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ALARM = 1'b1} state_t;

  localparam logic [3:0]       LP_RUN_LAST = 4'(RUN_LEN - 1);
  localparam logic [CNT_W-1:0] LP_CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] LP_CNT_ONE  = CNT_W'(1);

  state_t           r_state;
  logic [3:0]       r_run;
  logic             r_alarm;
  logic             r_rise;
  logic             r_fall;
  logic [CNT_W-1:0] r_gt;
  logic [CNT_W-1:0] r_eq;
  logic [CNT_W-1:0] r_lt;
  logic             r_err;

  logic w_onehot;
  logic w_good;
  logic w_bad;

  // Classify the current sample as good (exactly one flag) or bad.
  always_comb begin
    w_onehot = 1'b0;
    case ({A_greater, A_equal, A_less})
      3'b100, 3'b010, 3'b001: w_onehot = 1'b1;
      default:                w_onehot = 1'b0;
    endcase
    w_good = in_valid & w_onehot;
    w_bad  = in_valid & ~w_onehot;
  end

  // Alarm FSM, run counter, outcome counters and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_run   <= 4'd0;
      r_alarm <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_gt    <= '0;
      r_eq    <= '0;
      r_lt    <= '0;
      r_err   <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;

      // Clear wins over a same-cycle increment or error capture.
      if (clear_counts) begin
        r_gt  <= '0;
        r_eq  <= '0;
        r_lt  <= '0;
        r_err <= 1'b0;
      end else if (w_bad) begin
        r_err <= 1'b1;
      end else if (w_good) begin
        if (A_greater && (r_gt != LP_CNT_MAX)) r_gt <= r_gt + LP_CNT_ONE;
        if (A_equal   && (r_eq != LP_CNT_MAX)) r_eq <= r_eq + LP_CNT_ONE;
        if (A_less    && (r_lt != LP_CNT_MAX)) r_lt <= r_lt + LP_CNT_ONE;
      end

      if (w_good) begin
        case (r_state)
          ST_IDLE: begin
            if (!A_greater) begin
              r_run <= 4'd0;
            end else if (r_run == LP_RUN_LAST) begin
              r_state <= ST_ALARM;
              r_run   <= 4'd0;
              r_alarm <= 1'b1;
              r_rise  <= 1'b1;
            end else begin
              r_run <= r_run + 4'd1;
            end
          end
          ST_ALARM: begin
            if (A_greater) begin
              r_run <= 4'd0;
            end else if (r_run == LP_RUN_LAST) begin
              r_state <= ST_IDLE;
              r_run   <= 4'd0;
              r_alarm <= 1'b0;
              r_fall  <= 1'b1;
            end else begin
              r_run <= r_run + 4'd1;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_run   <= 4'd0;
            r_alarm <= 1'b0;
          end
        endcase
      end
    end
  end

  assign alarm      = r_alarm;
  assign alarm_rise = r_rise;
  assign alarm_fall = r_fall;
  assign gt_count   = r_gt;
  assign eq_count   = r_eq;
  assign lt_count   = r_lt;
  assign flag_error = r_err;

endmodule

// File: tb/tb_compare_alarm_monitor.sv
// Directed-vector bench for compare_alarm_monitor (RUN_LEN=3, CNT_W=4 so saturation is reachable).
module tb_compare_alarm_monitor;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             A_greater = 1'b0;
  logic             A_equal = 1'b0;
  logic             A_less = 1'b0;
  logic             clear_counts = 1'b0;
  logic             alarm, alarm_rise, alarm_fall, flag_error;
  logic [CNT_W-1:0] gt_count, eq_count, lt_count;

  int n_vec = 0;
  int n_err = 0;

  compare_alarm_monitor #(.CNT_W(CNT_W), .RUN_LEN(3)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .A_greater(A_greater), .A_equal(A_equal), .A_less(A_less),
    .clear_counts(clear_counts),
    .alarm(alarm), .alarm_rise(alarm_rise), .alarm_fall(alarm_fall),
    .gt_count(gt_count), .eq_count(eq_count), .lt_count(lt_count),
    .flag_error(flag_error)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs; outputs are sampled 1 time unit after the edge.
  task automatic apply(input logic v, input logic [2:0] gel, input logic clr);
    in_valid     = v;
    A_greater    = gel[2];
    A_equal      = gel[1];
    A_less       = gel[0];
    clear_counts = clr;
    @(posedge clk);
    #1;
    in_valid     = 1'b0;
    clear_counts = 1'b0;
  endtask

  task automatic check_state(input string tag, input logic a, input logic r, input logic f,
                             input int gt, input int eq, input int lt, input logic err);
    check_val({tag, ".alarm"}, 32'(alarm), 32'(a));
    check_val({tag, ".rise"},  32'(alarm_rise), 32'(r));
    check_val({tag, ".fall"},  32'(alarm_fall), 32'(f));
    check_val({tag, ".gt"},    32'(gt_count), gt);
    check_val({tag, ".eq"},    32'(eq_count), eq);
    check_val({tag, ".lt"},    32'(lt_count), lt);
    check_val({tag, ".err"},   32'(flag_error), 32'(err));
  endtask

  localparam logic [2:0] G = 3'b100, E = 3'b010, L = 3'b001;

  initial begin
    // Reset, then idle.
    apply(1'b0, 3'b000, 1'b0);
    apply(1'b0, 3'b000, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) apply(1'b0, 3'b000, 1'b0);
    check_state("reset_idle", 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0);

    // G,G,E,G,G,G back to back: the E restarts the run.
    apply(1'b1, G, 1'b0);
    apply(1'b1, G, 1'b0);
    apply(1'b1, E, 1'b0);
    check_state("after_E", 1'b0, 1'b0, 1'b0, 2, 1, 0, 1'b0);
    apply(1'b1, G, 1'b0);
    apply(1'b1, G, 1'b0);
    check_val("gge_5th_alarm", 32'(alarm), 32'd0);
    apply(1'b1, G, 1'b0);
    check_state("rise", 1'b1, 1'b1, 1'b0, 5, 1, 0, 1'b0);
    apply(1'b0, 3'b000, 1'b0);
    check_state("rise_drop", 1'b1, 1'b0, 1'b0, 5, 1, 0, 1'b0);

    // From ALARM: L,G,L,L,L with gaps between samples.
    apply(1'b1, L, 1'b0);
    apply(1'b0, 3'b000, 1'b0);
    apply(1'b1, G, 1'b0);
    apply(1'b0, 3'b000, 1'b0);
    apply(1'b1, L, 1'b0);
    apply(1'b0, 3'b000, 1'b0);
    apply(1'b1, L, 1'b0);
    apply(1'b0, 3'b000, 1'b0);
    apply(1'b0, 3'b000, 1'b0);
    check_state("pre_fall", 1'b1, 1'b0, 1'b0, 6, 1, 3, 1'b0);
    apply(1'b1, L, 1'b0);
    check_state("fall", 1'b0, 1'b0, 1'b1, 6, 1, 4, 1'b0);
    apply(1'b0, 3'b000, 1'b0);
    check_state("fall_drop", 1'b0, 1'b0, 1'b0, 6, 1, 4, 1'b0);

    // Bad samples between greaters: error sticks, run and counters untouched.
    apply(1'b1, G, 1'b0);
    apply(1'b1, 3'b110, 1'b0);
    apply(1'b1, 3'b000, 1'b0);
    check_state("bad", 1'b0, 1'b0, 1'b0, 7, 1, 4, 1'b1);
    apply(1'b1, G, 1'b0);
    check_state("bad_sticky", 1'b0, 1'b0, 1'b0, 8, 1, 4, 1'b1);
    apply(1'b1, 3'b011, 1'b1);
    check_state("clr_bad", 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    apply(1'b1, G, 1'b0);
    check_state("run_kept", 1'b1, 1'b1, 1'b0, 1, 0, 0, 1'b0);

    // clear_counts with a good sample: not counted, but still advances the run.
    apply(1'b1, L, 1'b1);
    check_state("clr_good", 1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    apply(1'b1, L, 1'b0);
    check_val("clr_run_alarm", 32'(alarm), 32'd1);
    apply(1'b1, L, 1'b0);
    check_state("clr_run_fall", 1'b0, 1'b0, 1'b1, 0, 0, 2, 1'b0);

    // Saturation: 20 greaters, alarm rises on the 3rd.
    for (int i = 1; i <= 20; i++) begin
      apply(1'b1, G, 1'b0);
      if (i == 2) check_val("sat_2_alarm", 32'(alarm), 32'd0);
      if (i == 3) check_state("sat_3", 1'b1, 1'b1, 1'b0, 3, 0, 2, 1'b0);
      if (i == 15) check_val("sat_15_gt", 32'(gt_count), 32'd15);
    end
    check_state("sat_20", 1'b1, 1'b0, 1'b0, 15, 0, 2, 1'b0);

    // Reset while in ALARM, overriding a same-cycle sample.
    reset = 1'b1;
    apply(1'b1, L, 1'b0);
    reset = 1'b0;
    check_state("rst_alarm", 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0);

    // Reset mid-run in IDLE (run=2): a full 3 greaters are needed afterwards.
    apply(1'b1, G, 1'b0);
    apply(1'b1, G, 1'b0);
    reset = 1'b1;
    apply(1'b1, G, 1'b0);
    reset = 1'b0;
    check_state("rst_idle", 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    apply(1'b1, G, 1'b0);
    apply(1'b1, G, 1'b0);
    check_state("post_rst_2", 1'b0, 1'b0, 1'b0, 2, 0, 0, 1'b0);
    apply(1'b1, G, 1'b0);
    check_state("post_rst_3", 1'b1, 1'b1, 1'b0, 3, 0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
